// File: rtl/nibble_sequencer.sv
// Fetch/execute controller for the 4-bit ALU/accumulator datapath.
// Optional CALL/RET support is enabled by defining NIBBLE_SEQ_CALL_EN.
module nibble_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] rom_data,
  input  logic       c_in,
  input  logic       z_in,
  output logic [7:0] rom_addr,
  output logic [2:0] sel,
  output logic       accu_en,
  output logic       bus1_en,
  output logic       bus2_en,
  output logic [3:0] operand,
  output logic       out_valid,
  output logic       flag_c,
  output logic       flag_z,
  output logic       halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_JADDR, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LIT  = 4'h1, OP_ADDI = 4'h2, OP_CMPI = 4'h3,
    OP_NAND = 4'h4, OP_SUBI = 4'h5, OP_OUT  = 4'h6, OP_JMP  = 4'h7,
    OP_JC   = 4'h8, OP_JNC  = 4'h9, OP_JZ   = 4'hA, OP_JNZ  = 4'hB,
    OP_CALL = 4'hC, OP_RET  = 4'hD, OP_RSV  = 4'hE, OP_HALT = 4'hF
  } op_t;

  state_t     state, state_nx;
  logic [7:0] pc, pc_nx;
  logic [7:0] ir, ir_nx;
  logic       flags_ld;
  op_t        op;

`ifdef NIBBLE_SEQ_CALL_EN
  logic [7:0] ret, ret_nx;
`endif

  assign op = op_t'(ir[7:4]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
`ifdef NIBBLE_SEQ_CALL_EN
      ret    <= '0;
`endif
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      if (flags_ld) begin
        flag_c <= c_in;
        flag_z <= z_in;
      end
`ifdef NIBBLE_SEQ_CALL_EN
      ret   <= ret_nx;
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_nx     = ir;
    rom_addr  = pc;
    sel       = 3'd0;
    accu_en   = 1'b0;
    bus1_en   = 1'b0;
    bus2_en   = 1'b0;
    operand   = '0;
    out_valid = 1'b0;
    flags_ld  = 1'b0;
    halted    = 1'b0;
`ifdef NIBBLE_SEQ_CALL_EN
    ret_nx    = ret;
`endif

    unique case (state)
      S_FETCH: begin
        if (run) begin
          ir_nx    = rom_data;
          pc_nx    = pc + 8'd1;
          state_nx = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nx = S_FETCH;
        case (op)
          OP_LIT: begin
            sel = 3'd2; bus1_en = 1'b1; accu_en = 1'b1; operand = ir[3:0]; flags_ld = 1'b1;
          end
          OP_ADDI: begin
            sel = 3'd3; bus1_en = 1'b1; accu_en = 1'b1; operand = ir[3:0]; flags_ld = 1'b1;
          end
          OP_CMPI: begin
            sel = 3'd1; bus1_en = 1'b1; operand = ir[3:0]; flags_ld = 1'b1;
          end
          OP_NAND: begin
            sel = 3'd4; bus1_en = 1'b1; accu_en = 1'b1; operand = ir[3:0]; flags_ld = 1'b1;
          end
          OP_SUBI: begin
            sel = 3'd1; bus1_en = 1'b1; accu_en = 1'b1; operand = ir[3:0]; flags_ld = 1'b1;
          end
          OP_OUT: begin
            bus2_en = 1'b1; out_valid = 1'b1;
          end
          // PC already points at the target byte; JADDR reads it, a miss skips it
          OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: begin
            if ((op == OP_JMP) ||
                (op == OP_JC  &&  flag_c) || (op == OP_JNC && !flag_c) ||
                (op == OP_JZ  &&  flag_z) || (op == OP_JNZ && !flag_z))
              state_nx = S_JADDR;
            else
              pc_nx = pc + 8'd1;
          end
`ifdef NIBBLE_SEQ_CALL_EN
          OP_CALL: begin
            ret_nx   = pc + 8'd1;
            state_nx = S_JADDR;
          end
          OP_RET: pc_nx = ret;
`endif
          OP_HALT: state_nx = S_HALT;
          default: ;
        endcase
      end

      S_JADDR: begin
        pc_nx    = rom_data;
        state_nx = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_nibble_sequencer.sv
// Bench for nibble_sequencer: a toy datapath and ROM around the DUT, checked
// cycle by cycle against an instruction-level interpreter.
module tb_nibble_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] rom_data, rom_addr;
  logic       c_in, z_in;
  logic [2:0] sel;
  logic       accu_en, bus1_en, bus2_en, out_valid, flag_c, flag_z, halted;
  logic [3:0] operand;

  logic [7:0] rom [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .rom_data(rom_data), .c_in(c_in), .z_in(z_in),
    .rom_addr(rom_addr), .sel(sel), .accu_en(accu_en), .bus1_en(bus1_en), .bus2_en(bus2_en),
    .operand(operand), .out_valid(out_valid), .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
  );

  assign rom_data = rom[rom_addr];

  // Attached datapath: accumulator plus ALU
  logic [3:0] dp_acc, alu_b, alu_r;
  logic       alu_c;

  always_comb begin
    alu_b = bus1_en ? operand : 4'h0;
    alu_r = dp_acc;
    alu_c = 1'b0;
    case (sel)
      3'd1: begin alu_r = dp_acc - alu_b; alu_c = (dp_acc < alu_b); end
      3'd2: alu_r = alu_b;
      3'd3: {alu_c, alu_r} = {1'b0, dp_acc} + {1'b0, alu_b};
      3'd4: alu_r = ~(dp_acc & alu_b);
      default: ;
    endcase
  end

  assign c_in = alu_c;
  assign z_in = (alu_r == 4'h0);

  always_ff @(posedge clk or negedge reset)
    if (!reset) dp_acc <= '0;
    else if (accu_en) dp_acc <= alu_r;

  // Expected per-cycle observation
  typedef struct {
    bit       is_fetch;
    bit       chk_addr;
    bit [7:0] addr;
    bit [2:0] sel;
    bit       accu, b1, b2, ov, halted, c, z;
    bit [3:0] opnd;
    bit [3:0] outv;
  } rec_t;

  rec_t     q[$];
  bit [7:0] m_pc, m_ret;
  bit [3:0] m_acc;
  bit       m_c, m_z, m_halt;

  function automatic rec_t idle(input bit [7:0] a);
    rec_t r;
    r = '{default: 0};
    r.chk_addr = 1'b1;
    r.addr = a;
    r.c = m_c;
    r.z = m_z;
    return r;
  endfunction

  // Interpret one instruction at m_pc, queueing the cycles it should produce
  task automatic gen();
    rec_t r, e;
    bit [7:0] b;
    bit [3:0] op, n;
    int res;
    bit c, upd, wr, taken;
    if (m_halt) begin
      r = idle(m_pc); r.halted = 1'b1; q.push_back(r);
      return;
    end
    r = idle(m_pc); r.is_fetch = 1'b1; q.push_back(r);
    b = rom[m_pc]; m_pc = m_pc + 8'd1; op = b[7:4]; n = b[3:0];
    e = idle(m_pc); e.chk_addr = 1'b0;
    upd = 0; wr = 1; res = 0; c = 0;
    case (op)
      4'h1: begin e.sel = 2; res = n; upd = 1; end
      4'h2: begin e.sel = 3; res = int'(m_acc) + int'(n); c = (res > 15); upd = 1; end
      4'h3: begin e.sel = 1; res = int'(m_acc) - int'(n); c = (m_acc < n); upd = 1; wr = 0; end
      4'h4: begin e.sel = 4; res = int'(~(m_acc & n)); upd = 1; end
      4'h5: begin e.sel = 1; res = int'(m_acc) - int'(n); c = (m_acc < n); upd = 1; end
      4'h6: begin e.b2 = 1; e.ov = 1; e.outv = m_acc; end
      4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
        taken = (op == 4'h7) || (op == 4'h8 && m_c) || (op == 4'h9 && !m_c) ||
                (op == 4'hA && m_z) || (op == 4'hB && !m_z);
        q.push_back(e);
        if (taken) begin
          q.push_back(idle(m_pc));
          m_pc = rom[m_pc];
        end else m_pc = m_pc + 8'd1;
        return;
      end
`ifdef NIBBLE_SEQ_CALL_EN
      4'hC: begin
        q.push_back(e);
        q.push_back(idle(m_pc));
        m_ret = m_pc + 8'd1;
        m_pc = rom[m_pc];
        return;
      end
      4'hD: begin
        q.push_back(e);
        m_pc = m_ret;
        return;
      end
`endif
      4'hF: begin
        q.push_back(e);
        m_halt = 1;
        return;
      end
      default: ;
    endcase
    if (upd) begin e.b1 = 1; e.accu = wr; e.opnd = n; end
    q.push_back(e);
    if (upd) begin
      m_c = c;
      m_z = ((res & 15) == 0);
      if (wr) m_acc = res[3:0];
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    q.delete();
    m_pc = '0; m_ret = '0; m_acc = '0; m_c = 0; m_z = 0; m_halt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_cycles(input int cycles, input int stall_pct);
    rec_t r;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (q.size() == 0) gen();
      r = q[0];
      if (r.chk_addr) check("rom_addr", rom_addr, r.addr);
      check("sel",       {5'd0, sel},       {5'd0, r.sel});
      check("accu_en",   {7'd0, accu_en},   {7'd0, r.accu});
      check("bus1_en",   {7'd0, bus1_en},   {7'd0, r.b1});
      check("bus2_en",   {7'd0, bus2_en},   {7'd0, r.b2});
      check("operand",   {4'd0, operand},   {4'd0, r.opnd});
      check("out_valid", {7'd0, out_valid}, {7'd0, r.ov});
      check("flag_c",    {7'd0, flag_c},    {7'd0, r.c});
      check("flag_z",    {7'd0, flag_z},    {7'd0, r.z});
      check("halted",    {7'd0, halted},    {7'd0, r.halted});
      if (r.ov) check("bus2_data", {4'd0, alu_r}, {4'd0, r.outv});
      run = ($urandom_range(99) >= stall_pct);
      if (!(r.is_fetch && !run)) void'(q.pop_front());
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;

    // Reset state
    clear_rom();
    do_reset();
    #1;
    check("rst_rom_addr", rom_addr, 8'h00);
    check("rst_halted", {7'd0, halted}, 8'h00);

    // LIT 5, ADDI 3, OUT, HALT
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h60; rom[3] = 8'hF0;
    do_reset();
    run_cycles(12, 0);
    check("t1_halted", {7'd0, halted}, 8'h01);
    check("t1_acc", {4'd0, dp_acc}, 8'h08);

    // JC taken after carry out of ADDI
    clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h80; rom[3] = 8'h10; rom[4] = 8'hF0;
    rom[8'h10] = 8'h60; rom[8'h11] = 8'hF0;
    do_reset();
    run_cycles(14, 0);
    check("t2_acc", {4'd0, dp_acc}, 8'h00);

    // Same program, no carry: JC falls through to address 4
    rom[1] = 8'h20;
    do_reset();
    run_cycles(12, 0);
    check("t2b_acc", {4'd0, dp_acc}, 8'h0F);

    // CMPI equal sets Z without loading the accumulator, JZ taken
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h33; rom[2] = 8'hA0; rom[3] = 8'h08;
    rom[8] = 8'h60; rom[9] = 8'hF0;
    do_reset();
    run_cycles(14, 0);
    check("t3_acc", {4'd0, dp_acc}, 8'h03);
    check("t3_flag_z", {7'd0, flag_z}, 8'h01);

    // Stall in FETCH, then resume
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h60; rom[3] = 8'hF0;
    do_reset();
    run_cycles(3, 0);
    run_cycles(6, 100);
    run_cycles(14, 0);

    // Asynchronous reset in the middle of an ADDI EXEC cycle
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h22; rom[2] = 8'hF0;
    do_reset();
    run_cycles(3, 0);
    @(negedge clk);
    check("pre_rst_accu_en", {7'd0, accu_en}, 8'h01);
    check("pre_rst_flag_z", {7'd0, flag_z}, 8'h01);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_accu_en", {7'd0, accu_en}, 8'h00);
    check("mid_rst_bus1_en", {7'd0, bus1_en}, 8'h00);
    check("mid_rst_sel", {5'd0, sel}, 8'h00);
    check("mid_rst_flag_z", {7'd0, flag_z}, 8'h00);
    check("mid_rst_flag_c", {7'd0, flag_c}, 8'h00);
    check("mid_rst_rom_addr", rom_addr, 8'h00);
    @(posedge clk); #1;
    check("mid_rst_acc", {4'd0, dp_acc}, 8'h00);
    do_reset();
    run_cycles(8, 0);

    // PC wrap: jump at 0xFF takes its target from 0x00
    clear_rom();
    rom[0] = 8'h70; rom[1] = 8'hFE; rom[8'hFE] = 8'h00; rom[8'hFF] = 8'h70;
    rom[8'h70] = 8'h17; rom[8'h71] = 8'h60; rom[8'h72] = 8'hF0;
    do_reset();
    run_cycles(20, 0);
    check("wrap_acc", {4'd0, dp_acc}, 8'h07);

    // CALL/RET program (0xC0/0xD0 are NOPs when the option is off)
    clear_rom();
    rom[0] = 8'hC0; rom[1] = 8'h05; rom[2] = 8'hF0; rom[5] = 8'h17; rom[6] = 8'hD0;
    do_reset();
    run_cycles(16, 0);
    check("call_halted", {7'd0, halted}, 8'h01);
`ifdef NIBBLE_SEQ_CALL_EN
    check("call_acc", {4'd0, dp_acc}, 8'h07);
`else
    check("call_acc", {4'd0, dp_acc}, 8'h00);
`endif

    // Random programs with random stalls
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      do_reset();
      run_cycles(150, 25);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
